// File: rtl/k_and_s_pkg.sv
// Shared types for the K&S control path.
// Holds the decoded-opcode enum, the control FSM state enum and the ALU op codes.
// alu_op() maps an ALU-class opcode to the 2-bit datapath operation.
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP,
    I_LOAD,
    I_STORE,
    I_MOVE,
    I_ADD,
    I_SUB,
    I_AND,
    I_OR,
    I_BRANCH,
    I_BZERO,
    I_BNZERO,
    I_BNEG,
    I_BNNEG,
    I_BOV,
    I_BNOV,
    I_HALT
  } decoded_instruction_type;

  typedef enum logic [3:0] {
    FETCH,
    REG_IR,
    DECODE,
    LD_WAIT,
    LD_WB,
    ST_WAIT,
    ST_WR,
    EX1,
    EX2,
    BR,
    HALT
  } ctrl_state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // MOVE rides the AND path; the datapath feeds the source on both ALU inputs.
  function automatic logic [1:0] alu_op(input decoded_instruction_type ins);
    logic [1:0] op;
    op = ALU_ADD;
    case (ins)
      I_SUB:  op = ALU_SUB;
      I_AND:  op = ALU_AND;
      I_OR:   op = ALU_OR;
      I_MOVE: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ks_wait_counter.sv
// Memory wait-state counter shared by FETCH, LD_WAIT and ST_WAIT.
// Ports: clk, rst_n (sync, active-low), start (clear), run (count enable),
//        done (high while the count sits at MEM_LATENCY-1).
module ks_wait_counter #(
  parameter int MEM_LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  output logic done
);

  localparam int CW = $clog2(MEM_LATENCY + 1);

  logic [CW-1:0] cnt;

  assign done = (cnt == CW'(MEM_LATENCY - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/control_unit_mw.sv
// Multi-cycle control FSM for the K&S datapath with configurable RAM wait states.
// Inputs: clk, rst_n (sync, active-low), decoded_instruction, flag inputs, halt_release.
// Outputs: datapath/RAM enables, ALU operation, halt, saturating retired_cnt.
module control_unit_mw
  import k_and_s_pkg::*;
#(
  parameter int MEM_LATENCY   = 1,
  parameter int BOV_SIGNED    = 0,
  parameter int FLAGS_ON_MOVE = 0,
  parameter int RET_CNT_W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  decoded_instruction_type  decoded_instruction,
  input  logic                     zero_op,
  input  logic                     neg_op,
  input  logic                     unsigned_overflow,
  input  logic                     signed_overflow,
  input  logic                     halt_release,
  output logic                     branch,
  output logic                     pc_enable,
  output logic                     ir_enable,
  output logic                     write_reg_enable,
  output logic                     addr_sel,
  output logic                     c_sel,
  output logic [1:0]               operation,
  output logic                     flags_reg_enable,
  output logic                     ram_write_enable,
  output logic                     halt,
  output logic [RET_CNT_W-1:0]     retired_cnt
);

  ctrl_state_t state;
  ctrl_state_t state_nxt;
  logic        in_wait;
  logic        wait_done;
  logic        retire;
  logic        ov;
  logic        cond;
  logic        alu_flags;

  assign in_wait   = (state == FETCH) || (state == LD_WAIT) || (state == ST_WAIT);
  assign ov        = (BOV_SIGNED != 0) ? signed_overflow : unsigned_overflow;
  assign alu_flags = (decoded_instruction != I_MOVE) || (FLAGS_ON_MOVE != 0);

  // Every wait state exits on done, so clearing on done re-arms the counter
  // for the next wait state without an extra cycle.
  ks_wait_counter #(
    .MEM_LATENCY (MEM_LATENCY)
  ) u_wait (
    .clk   (clk),
    .rst_n (rst_n),
    .start (wait_done | ~in_wait),
    .run   (in_wait),
    .done  (wait_done)
  );

  always_comb begin
    cond = 1'b0;
    case (decoded_instruction)
      I_BRANCH: cond = 1'b1;
      I_BZERO:  cond = zero_op;
      I_BNZERO: cond = ~zero_op;
      I_BNEG:   cond = neg_op;
      I_BNNEG:  cond = ~neg_op;
      I_BOV:    cond = ov;
      I_BNOV:   cond = ~ov;
      default:  cond = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt        = state;
    retire           = 1'b0;
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    write_reg_enable = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = ALU_ADD;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    case (state)
      FETCH: begin
        if (wait_done) state_nxt = REG_IR;
      end
      REG_IR: begin
        ir_enable = 1'b1;
        pc_enable = 1'b1;
        state_nxt = DECODE;
      end
      DECODE: begin
        case (decoded_instruction)
          I_HALT: begin
            state_nxt = HALT;
            retire    = 1'b1;
          end
          I_LOAD:  state_nxt = LD_WAIT;
          I_STORE: state_nxt = ST_WAIT;
          I_MOVE, I_ADD, I_SUB, I_AND, I_OR: state_nxt = EX1;
          I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV:
            state_nxt = BR;
          default: begin
            state_nxt = FETCH;
            retire    = 1'b1;
          end
        endcase
      end
      LD_WAIT: begin
        addr_sel = 1'b1;
        if (wait_done) state_nxt = LD_WB;
      end
      LD_WB: begin
        addr_sel         = 1'b1;
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        state_nxt        = FETCH;
        retire           = 1'b1;
      end
      ST_WAIT: begin
        addr_sel = 1'b1;
        if (wait_done) state_nxt = ST_WR;
      end
      ST_WR: begin
        addr_sel         = 1'b1;
        ram_write_enable = 1'b1;
        state_nxt        = FETCH;
        retire           = 1'b1;
      end
      EX1: begin
        operation        = alu_op(decoded_instruction);
        flags_reg_enable = alu_flags;
        state_nxt        = EX2;
      end
      EX2: begin
        operation        = alu_op(decoded_instruction);
        flags_reg_enable = alu_flags;
        write_reg_enable = 1'b1;
        state_nxt        = FETCH;
        retire           = 1'b1;
      end
      BR: begin
        branch    = cond;
        pc_enable = cond;
        state_nxt = FETCH;
        retire    = 1'b1;
      end
      HALT: begin
        halt = 1'b1;
        if (halt_release) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FETCH;
      retired_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (retire && (retired_cnt != '1)) begin
        retired_cnt <= retired_cnt + RET_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_control_unit_mw.sv
module tb_control_unit_mw;
  import k_and_s_pkg::*;

  typedef struct packed {
    logic [10:0] v;
    logic [31:0] rc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: L=1, unsigned BOV, no flags on MOVE, 32-bit counter
  logic rst_a;
  decoded_instruction_type ins_a;
  logic z_a, n_a, uo_a, so_a, rel_a;
  logic br_a, pc_a, ir_a, wr_a, as_a, cs_a, fl_a, rw_a, ht_a;
  logic [1:0] op_a;
  logic [31:0] rc_a;

  // DUT B: L=3, signed BOV, flags on MOVE, 2-bit counter
  logic rst_b;
  decoded_instruction_type ins_b;
  logic z_b, n_b, uo_b, so_b, rel_b;
  logic br_b, pc_b, ir_b, wr_b, as_b, cs_b, fl_b, rw_b, ht_b;
  logic [1:0] op_b;
  logic [1:0] rc_b;

  control_unit_mw #(.MEM_LATENCY(1), .BOV_SIGNED(0), .FLAGS_ON_MOVE(0), .RET_CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_a), .decoded_instruction(ins_a),
    .zero_op(z_a), .neg_op(n_a), .unsigned_overflow(uo_a), .signed_overflow(so_a),
    .halt_release(rel_a), .branch(br_a), .pc_enable(pc_a), .ir_enable(ir_a),
    .write_reg_enable(wr_a), .addr_sel(as_a), .c_sel(cs_a), .operation(op_a),
    .flags_reg_enable(fl_a), .ram_write_enable(rw_a), .halt(ht_a), .retired_cnt(rc_a));

  control_unit_mw #(.MEM_LATENCY(3), .BOV_SIGNED(1), .FLAGS_ON_MOVE(1), .RET_CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_b), .decoded_instruction(ins_b),
    .zero_op(z_b), .neg_op(n_b), .unsigned_overflow(uo_b), .signed_overflow(so_b),
    .halt_release(rel_b), .branch(br_b), .pc_enable(pc_b), .ir_enable(ir_b),
    .write_reg_enable(wr_b), .addr_sel(as_b), .c_sel(cs_b), .operation(op_b),
    .flags_reg_enable(fl_b), .ram_write_enable(rw_b), .halt(ht_b), .retired_cnt(rc_b));

  exp_t qa[$];
  exp_t qb[$];
  int   ret_a;
  int   ret_b;
  int   n_chk  = 0;
  int   n_pass = 0;

  // Packing order: branch, pc_enable, ir_enable, write_reg_enable, addr_sel,
  // c_sel, operation[1:0], flags_reg_enable, ram_write_enable, halt
  function automatic logic [10:0] vec(input bit br, input bit pc, input bit ir, input bit wr,
                                      input bit as_, input bit cs, input logic [1:0] op,
                                      input bit fl, input bit rw, input bit ht);
    return {br, pc, ir, wr, as_, cs, op, fl, rw, ht};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  task automatic push(input int d, input logic [10:0] v);
    exp_t e;
    e.v  = v;
    e.rc = (d == 0) ? ret_a : ret_b;
    if (d == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  task automatic bump(input int d);
    if (d == 0) ret_a++;
    else if (ret_b < 3) ret_b++;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at the start of a FETCH cycle; pushes the full expected trace of one
  // instruction and waits until it has retired.
  task automatic run_instr(input int d, input decoded_instruction_type ins,
                           input bit z, input bit n, input bit uo, input bit so,
                           input bit taken);
    int L;
    int cyc;
    bit fom;
    logic [1:0] op;
    L   = (d == 0) ? 1 : 3;
    fom = (d == 1);
    if (d == 0) begin ins_a = ins; z_a = z; n_a = n; uo_a = uo; so_a = so; end
    else        begin ins_b = ins; z_b = z; n_b = n; uo_b = uo; so_b = so; end
    repeat (L) push(d, vec(0,0,0,0,0,0,2'b00,0,0,0));
    push(d, vec(0,1,1,0,0,0,2'b00,0,0,0));
    push(d, vec(0,0,0,0,0,0,2'b00,0,0,0));
    cyc = L + 2;
    case (ins)
      I_LOAD: begin
        repeat (L) push(d, vec(0,0,0,0,1,0,2'b00,0,0,0));
        push(d, vec(0,0,0,1,1,1,2'b00,0,0,0));
        cyc += L + 1;
      end
      I_STORE: begin
        repeat (L) push(d, vec(0,0,0,0,1,0,2'b00,0,0,0));
        push(d, vec(0,0,0,0,1,0,2'b00,0,1,0));
        cyc += L + 1;
      end
      I_ADD, I_SUB, I_AND, I_OR, I_MOVE: begin
        case (ins)
          I_SUB:   op = 2'b01;
          I_AND:   op = 2'b10;
          I_OR:    op = 2'b11;
          I_MOVE:  op = 2'b10;
          default: op = 2'b00;
        endcase
        push(d, vec(0,0,0,0,0,0,op,(ins != I_MOVE) || fom,0,0));
        push(d, vec(0,0,0,1,0,0,op,(ins != I_MOVE) || fom,0,0));
        cyc += 2;
      end
      I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: begin
        push(d, vec(taken,taken,0,0,0,0,2'b00,0,0,0));
        cyc += 1;
      end
      default: ;
    endcase
    bump(d);
    wait_cycles(cyc);
  endtask

  // Called at the start of the first HALT cycle.
  task automatic halt_hold(input int d, input int hold);
    repeat (hold + 1) push(d, vec(0,0,0,0,0,0,2'b00,0,0,1));
    wait_cycles(hold);
    if (d == 0) rel_a = 1'b1; else rel_b = 1'b1;
    wait_cycles(1);
    if (d == 0) rel_a = 1'b0; else rel_b = 1'b0;
  endtask

  // STORE on DUT B interrupted by reset in the first ST_WAIT cycle.
  task automatic reset_mid_store();
    ins_b = I_STORE;
    repeat (3) push(1, vec(0,0,0,0,0,0,2'b00,0,0,0));
    push(1, vec(0,1,1,0,0,0,2'b00,0,0,0));
    push(1, vec(0,0,0,0,0,0,2'b00,0,0,0));
    push(1, vec(0,0,0,0,1,0,2'b00,0,0,0));
    wait_cycles(5);
    rst_b = 1'b0;
    wait_cycles(1);
    rst_b = 1'b1;
    ret_b = 0;
  endtask

  exp_t ea;
  exp_t eb;

  always @(negedge clk) begin
    if (qa.size() != 0) begin
      ea = qa.pop_front();
      chk("A_outputs", {21'b0, br_a, pc_a, ir_a, wr_a, as_a, cs_a, op_a, fl_a, rw_a, ht_a}, {21'b0, ea.v});
      chk("A_retired_cnt", rc_a, ea.rc);
    end
  end

  always @(negedge clk) begin
    if (qb.size() != 0) begin
      eb = qb.pop_front();
      chk("B_outputs", {21'b0, br_b, pc_b, ir_b, wr_b, as_b, cs_b, op_b, fl_b, rw_b, ht_b}, {21'b0, eb.v});
      chk("B_retired_cnt", {30'b0, rc_b}, eb.rc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete (got timeout, expected completion)");
    n_chk++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    ins_a = I_NOP; ins_b = I_NOP;
    {z_a, n_a, uo_a, so_a, rel_a} = '0;
    {z_b, n_b, uo_b, so_b, rel_b} = '0;
    ret_a = 0; ret_b = 0;
    @(posedge clk); #1;
    push(0, vec(0,0,0,0,0,0,2'b00,0,0,0));
    push(1, vec(0,0,0,0,0,0,2'b00,0,0,0));
    @(posedge clk); #1;
    rst_a = 1'b1; rst_b = 1'b1;
    fork
      begin
        run_instr(0, I_ADD,    0,0,0,0, 0);
        run_instr(0, I_SUB,    0,0,0,0, 0);
        run_instr(0, I_AND,    0,0,0,0, 0);
        run_instr(0, I_OR,     0,0,0,0, 0);
        run_instr(0, I_MOVE,   0,0,0,0, 0);
        run_instr(0, I_LOAD,   0,0,0,0, 0);
        run_instr(0, I_STORE,  0,0,0,0, 0);
        run_instr(0, I_BRANCH, 0,0,0,0, 1);
        run_instr(0, I_BZERO,  1,0,0,0, 1);
        run_instr(0, I_BZERO,  0,0,0,0, 0);
        run_instr(0, I_BNZERO, 0,0,0,0, 1);
        run_instr(0, I_BNEG,   0,1,0,0, 1);
        run_instr(0, I_BNNEG,  0,1,0,0, 0);
        run_instr(0, I_BOV,    0,0,0,1, 0);
        run_instr(0, I_BNOV,   0,0,0,1, 1);
        run_instr(0, I_NOP,    0,0,0,0, 0);
        run_instr(0, I_HALT,   0,0,0,0, 0);
        halt_hold(0, 10);
        rel_a = 1'b1;
        run_instr(0, I_ADD,    0,0,0,0, 0);
        rel_a = 1'b0;
      end
      begin
        run_instr(1, I_LOAD,   0,0,0,0, 0);
        run_instr(1, I_MOVE,   0,0,0,0, 0);
        run_instr(1, I_BOV,    0,0,0,1, 1);
        run_instr(1, I_BNOV,   0,0,1,0, 1);
        reset_mid_store();
        repeat (5) run_instr(1, I_NOP, 0,0,0,0, 0);
        run_instr(1, I_HALT,   0,0,0,0, 0);
        halt_hold(1, 3);
        run_instr(1, I_STORE,  0,0,0,0, 0);
      end
    join
    repeat (2) @(posedge clk);
    chk("A_queue_drained", qa.size(), 0);
    chk("B_queue_drained", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
